register_file_p: RTL and testbench

Parametrised successor to the 8x16 register file: DEPTH = 2^ADDR_W registers of DATA_W bits, one write port and two read ports (R, S). Adds registered reads with write-to-read bypass, a per-register busy scoreboard for the issue stage, an optional hard-wired zero R0, and a sequenced clear sweep. It sits between the decode/issue logic and the ALU operand latches of the integer datapath.

---
 rtl/register_file_p_if.sv | 33 +++
 rtl/register_file_p.sv | 137 +++++++++++++
 tb/tb_register_file_p.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_p_if.sv
// Bus bundle between issue logic (master) and the register file (slave).
// Carries the write port, two read ports, the scoreboard and the clear sweep.
interface register_file_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int DEPTH = 1 << ADDR_W;

  logic              we;
  logic [ADDR_W-1:0] W_Adr;
  logic [DATA_W-1:0] W;
  logic [ADDR_W-1:0] R_Adr;
  logic [ADDR_W-1:0] S_Adr;
  logic [DATA_W-1:0] R;
  logic [DATA_W-1:0] S;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_Adr;
  logic              R_busy;
  logic              S_busy;
  logic [DEPTH-1:0]  busy;
  logic              clr;
  logic              sweeping;

  modport master (
    output we, W_Adr, W, R_Adr, S_Adr, rsv, rsv_Adr, clr,
    input  R, S, R_busy, S_busy, busy, sweeping
  );

  modport slave (
    input  we, W_Adr, W, R_Adr, S_Adr, rsv, rsv_Adr, clr,
    output R, S, R_busy, S_busy, busy, sweeping
  );
endinterface

// File: rtl/register_file_p.sv
// Parametrised register file: one write port, two registered read ports with
// write bypass, per-register busy scoreboard, optional zero R0, clear sweep.
module register_file_p #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             reset,
  register_file_p_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_sweeping;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DATA_W-1:0] r_R;
  logic [DATA_W-1:0] r_S;
  logic              r_R_busy;
  logic              r_S_busy;

  logic              w_idle;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_adr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_rsv_en;
  logic [DEPTH-1:0]  w_busy_next;
  logic [DATA_W-1:0] w_R_next;
  logic [DATA_W-1:0] w_S_next;

  // The sweep borrows the write port; user writes and reserves are ignored.
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_wr_en   = w_idle ? bus.we : 1'b1;
    w_wr_adr  = w_idle ? bus.W_Adr : r_cnt;
    w_wr_data = w_idle ? bus.W : '0;
    if ((ZERO_R0 != 0) && (w_wr_adr == '0)) begin
      w_wr_en = 1'b0;
    end
    w_rsv_en = w_idle && bus.rsv && !((ZERO_R0 != 0) && (bus.rsv_Adr == '0));
  end

  // Reserve beats a same-edge write, so the bit stays set.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      if ((ZERO_R0 != 0) && (gi == 0)) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_live
        assign w_busy_next[gi] =
          (w_rsv_en && (bus.rsv_Adr == ADDR_W'(gi))) ? 1'b1 :
          (w_wr_en  && (w_wr_adr    == ADDR_W'(gi))) ? 1'b0 :
          r_busy[gi];
      end
    end
  endgenerate

  always_comb begin
    w_R_next = r_mem[bus.R_Adr];
    if ((ZERO_R0 != 0) && (bus.R_Adr == '0)) begin
      w_R_next = '0;
    end else if (w_wr_en && (w_wr_adr == bus.R_Adr)) begin
      w_R_next = w_wr_data;
    end
    w_S_next = r_mem[bus.S_Adr];
    if ((ZERO_R0 != 0) && (bus.S_Adr == '0)) begin
      w_S_next = '0;
    end else if (w_wr_en && (w_wr_adr == bus.S_Adr)) begin
      w_S_next = w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[w_wr_adr] <= w_wr_data;
      end
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sweeping <= 1'b0;
      r_R        <= '0;
      r_S        <= '0;
      r_R_busy   <= 1'b0;
      r_S_busy   <= 1'b0;
    end else begin
      r_R      <= w_R_next;
      r_S      <= w_S_next;
      r_R_busy <= w_busy_next[bus.R_Adr];
      r_S_busy <= w_busy_next[bus.S_Adr];
      case (r_state)
        ST_IDLE: begin
          if (bus.clr) begin
            r_state    <= ST_SWEEP;
            r_cnt      <= '0;
            r_sweeping <= 1'b1;
          end
        end
        ST_SWEEP: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == '1) begin
            r_state    <= ST_IDLE;
            r_sweeping <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_sweeping <= 1'b0;
        end
      endcase
    end
  end

  assign bus.R        = r_R;
  assign bus.S        = r_S;
  assign bus.R_busy   = r_R_busy;
  assign bus.S_busy   = r_S_busy;
  assign bus.busy     = r_busy;
  assign bus.sweeping = r_sweeping;
endmodule

// File: tb/tb_register_file_p.sv
// Self-checking bench: two instances (ZERO_R0 = 0 and 1) driven in lockstep and
// compared every cycle against an array-based reference model.
module tb_register_file_p;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra;
  logic [AW-1:0] sa;
  logic          rsv;
  logic [AW-1:0] rva;
  logic          clr;

  int n_checks;
  int n_errors;

  register_file_p_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  register_file_p_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign if0.we = we;   assign if1.we = we;
  assign if0.W_Adr = wa; assign if1.W_Adr = wa;
  assign if0.W = wd;    assign if1.W = wd;
  assign if0.R_Adr = ra; assign if1.R_Adr = ra;
  assign if0.S_Adr = sa; assign if1.S_Adr = sa;
  assign if0.rsv = rsv; assign if1.rsv = rsv;
  assign if0.rsv_Adr = rva; assign if1.rsv_Adr = rva;
  assign if0.clr = clr; assign if1.clr = clr;

  register_file_p #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  register_file_p #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: m_sw = -1 when idle, else the next address to clear.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DEPTH-1:0] m_busy [2];
  int m_sw [2];
  logic [DW-1:0] e_R [2];
  logic [DW-1:0] e_S [2];
  logic e_Rb [2];
  logic e_Sb [2];

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int a = 0; a < DEPTH; a++) m_mem[z][a] = '0;
      m_busy[z] = '0;
      m_sw[z] = -1;
      e_R[z] = '0; e_S[z] = '0; e_Rb[z] = 1'b0; e_Sb[z] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      bit idle;
      bit wen;
      int wadr;
      logic [DW-1:0] wdat;
      idle = (m_sw[z] < 0);
      wen  = idle ? we : 1'b1;
      wadr = idle ? int'(wa) : m_sw[z];
      wdat = idle ? wd : '0;
      if (z == 1 && wadr == 0) wen = 1'b0;
      if (wen) begin
        m_mem[z][wadr] = wdat;
        m_busy[z][wadr] = 1'b0;
      end
      if (idle && rsv && !(z == 1 && rva == 0)) m_busy[z][rva] = 1'b1;
      e_R[z]  = (z == 1 && ra == 0) ? '0 : m_mem[z][ra];
      e_S[z]  = (z == 1 && sa == 0) ? '0 : m_mem[z][sa];
      e_Rb[z] = m_busy[z][ra];
      e_Sb[z] = m_busy[z][sa];
      if (idle) begin
        if (clr) m_sw[z] = 0;
      end else begin
        m_sw[z] = (m_sw[z] == DEPTH - 1) ? -1 : m_sw[z] + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("R0", 32'(if0.R), 32'(e_R[0]));
    chk("S0", 32'(if0.S), 32'(e_S[0]));
    chk("Rb0", 32'(if0.R_busy), 32'(e_Rb[0]));
    chk("Sb0", 32'(if0.S_busy), 32'(e_Sb[0]));
    chk("busy0", 32'(if0.busy), 32'(m_busy[0]));
    chk("sweep0", 32'(if0.sweeping), 32'(m_sw[0] >= 0));
    chk("R1", 32'(if1.R), 32'(e_R[1]));
    chk("S1", 32'(if1.S), 32'(e_S[1]));
    chk("Rb1", 32'(if1.R_busy), 32'(e_Rb[1]));
    chk("Sb1", 32'(if1.S_busy), 32'(e_Sb[1]));
    chk("busy1", 32'(if1.busy), 32'(m_busy[1]));
    chk("sweep1", 32'(if1.sweeping), 32'(m_sw[1] >= 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    $display("t=%0t we=%b wa=%0d w=%h ra=%0d sa=%0d rsv=%b rva=%0d clr=%b | R=%h S=%h busy=%b sw=%b",
             $time, we, wa, wd, ra, sa, rsv, rva, clr, if0.R, if0.S, if0.busy, if0.sweeping);
  endtask

  task automatic idle_inputs();
    we = 0; wa = 0; wd = 0; ra = 0; sa = 0; rsv = 0; rva = 0; clr = 0;
  endtask

  task automatic fill_regs(input logic [DW-1:0] base);
    for (int a = 0; a < DEPTH; a++) begin
      we = 1; wa = AW'(a); wd = base + DW'(a); rsv = (a >= 4); rva = AW'(9 - a);
      ra = AW'(a); sa = AW'(a);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic count_sweep(input string nm);
    int n;
    n = if0.sweeping ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      we = 1; wa = AW'($urandom); wd = DW'($urandom); rsv = 1; rva = AW'($urandom);
      ra = AW'($urandom); sa = AW'($urandom); clr = 0;
      cycle();
      if (!if0.sweeping) break;
      n++;
    end
    idle_inputs();
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] sa;
    logic          rsv;
    logic [AW-1:0] rva;
    logic [DW-1:0] er0;
    logic [DW-1:0] es0;
    logic          erb0;
    logic [DEPTH-1:0] eb0;
    logic [DW-1:0] er1;
    logic [DEPTH-1:0] eb1;
  } vec_t;

  vec_t vt [9];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vt[0] = '{1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 16'h0000, 8'h00};
    vt[1] = '{1, 5, 16'hBEEF, 3, 5, 0, 0, 16'h1234, 16'hBEEF, 0, 8'h00, 16'h1234, 8'h00};
    vt[2] = '{0, 0, 16'h0000, 3, 5, 0, 0, 16'h1234, 16'hBEEF, 0, 8'h00, 16'h1234, 8'h00};
    vt[3] = '{1, 2, 16'hA5A5, 2, 2, 0, 0, 16'hA5A5, 16'hA5A5, 0, 8'h00, 16'hA5A5, 8'h00};
    vt[4] = '{0, 0, 16'h0000, 4, 2, 1, 4, 16'h0000, 16'hA5A5, 1, 8'h10, 16'h0000, 8'h10};
    vt[5] = '{1, 4, 16'h4444, 4, 4, 1, 4, 16'h4444, 16'h4444, 1, 8'h10, 16'h4444, 8'h10};
    vt[6] = '{1, 4, 16'h5555, 4, 4, 0, 0, 16'h5555, 16'h5555, 0, 8'h00, 16'h5555, 8'h00};
    vt[7] = '{1, 0, 16'hFFFF, 0, 3, 1, 0, 16'hFFFF, 16'h1234, 1, 8'h01, 16'h0000, 8'h00};
    vt[8] = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 8'h01, 16'h0000, 8'h00};

    reset = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; ra = vt[i].ra; sa = vt[i].sa;
      rsv = vt[i].rsv; rva = vt[i].rva; clr = 0;
      cycle();
      chk($sformatf("vec%0d_R0", i), 32'(if0.R), 32'(vt[i].er0));
      chk($sformatf("vec%0d_S0", i), 32'(if0.S), 32'(vt[i].es0));
      chk($sformatf("vec%0d_Rb0", i), 32'(if0.R_busy), 32'(vt[i].erb0));
      chk($sformatf("vec%0d_busy0", i), 32'(if0.busy), 32'(vt[i].eb0));
      chk($sformatf("vec%0d_R1", i), 32'(if1.R), 32'(vt[i].er1));
      chk($sformatf("vec%0d_busy1", i), 32'(if1.busy), 32'(vt[i].eb1));
    end
    idle_inputs();

    // Full sweep, with a write on the clr edge that the sweep must zero
    fill_regs(16'hC001);
    clr = 1; we = 1; wa = 6; wd = 16'h7777;
    cycle();
    count_sweep("sweep_len");
    for (int a = 0; a < DEPTH; a++) begin
      ra = AW'(a); sa = AW'(DEPTH - 1 - a);
      cycle();
      chk("post_sweep_R0", 32'(if0.R), 32'h0);
      chk("post_sweep_S0", 32'(if0.S), 32'h0);
    end
    chk("post_sweep_busy0", 32'(if0.busy), 32'h0);
    chk("post_sweep_busy1", 32'(if1.busy), 32'h0);
    idle_inputs();

    // Reset asserted mid-sweep at counter = 3
    fill_regs(16'h9001);
    clr = 1;
    cycle();
    clr = 0; ra = 7; sa = 6;
    repeat (3) cycle();
    chk("pre_rst_R_nonzero", 32'(if0.R != 0), 32'h1);
    reset = 0;
    #2;
    model_reset();
    chk("rst_R0", 32'(if0.R), 32'h0);
    chk("rst_S0", 32'(if0.S), 32'h0);
    chk("rst_busy0", 32'(if0.busy), 32'h0);
    chk("rst_sweep0", 32'(if0.sweeping), 32'h0);
    chk("rst_busy1", 32'(if1.busy), 32'h0);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1;
    idle_inputs();
    clr = 1;
    cycle();
    count_sweep("sweep_len_after_rst");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom); wd = DW'($urandom);
      ra = AW'($urandom); sa = AW'($urandom);
      rsv = ($urandom_range(0, 2) == 0);
      rva = AW'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
